// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU select codes and register constants for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_SEL_W      = 5;

    localparam logic [DEF_SEL_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [DEF_SEL_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [DEF_SEL_W-1:0] ALU_AND  = 5'd2;
    localparam logic [DEF_SEL_W-1:0] ALU_OR   = 5'd3;
    localparam logic [DEF_SEL_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [DEF_SEL_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [DEF_SEL_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [DEF_SEL_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [DEF_SEL_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [DEF_SEL_W-1:0] ALU_SLTU = 5'd9;

    localparam logic [DEF_REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand forwarding for one source register: x0, then MEM, then WB, then held data.
module fwd_mux #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     data,
    input  logic                  mem_en,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     result
);

    // NOTE: default first so every path assigns result and no latch is inferred.
    always_comb begin
        result = data;
        if (addr == '0) begin
            result = '0;
        end else if (mem_en && (mem_rd == addr)) begin
            result = mem_data;
        end else if (wb_en && (wb_rd == addr)) begin
            result = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards MEM/WB results
// into its operands and drives the ALU a/b/sel inputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int SEL_W      = DEF_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]     in_rs1_data,
    input  logic [DATA_W-1:0]     in_rs2_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [SEL_W-1:0]      in_alu_sel,
    input  logic                  in_use_pc,
    input  logic                  in_use_imm,
    input  logic                  in_reg_write,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic                  fwd_mem_en,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
    input  logic [DATA_W-1:0]     fwd_mem_data,
    input  logic                  fwd_wb_en,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0]     fwd_wb_data,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [SEL_W-1:0]      alu_sel,
    output logic [DATA_W-1:0]     out_rs2_data,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write
);

    logic                  valid_q;
    logic [DATA_W-1:0]     pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic [SEL_W-1:0]      sel_q;
    logic                  use_pc_q, use_imm_q, reg_write_q;

    logic [DATA_W-1:0]     in_rs1_fwd, in_rs2_fwd, rs1_fwd, rs2_fwd;
    logic                  wb_hit_rs1, wb_hit_rs2;

    assign in_ready = !valid_q || ex_ready || flush;

    // Incoming operands are forwarded before capture so a same-cycle MEM/WB write is not lost.
    fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_in_rs1 (
        .addr(in_rs1_addr), .data(in_rs1_data),
        .mem_en(fwd_mem_en), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data),
        .wb_en(fwd_wb_en), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .result(in_rs1_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_in_rs2 (
        .addr(in_rs2_addr), .data(in_rs2_data),
        .mem_en(fwd_mem_en), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data),
        .wb_en(fwd_wb_en), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .result(in_rs2_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rs1 (
        .addr(rs1_addr_q), .data(rs1_data_q),
        .mem_en(fwd_mem_en), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data),
        .wb_en(fwd_wb_en), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .result(rs1_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rs2 (
        .addr(rs2_addr_q), .data(rs2_data_q),
        .mem_en(fwd_mem_en), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data),
        .wb_en(fwd_wb_en), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .result(rs2_fwd)
    );

    assign wb_hit_rs1 = fwd_wb_en && (fwd_wb_rd == rs1_addr_q) && (rs1_addr_q != '0);
    assign wb_hit_rs2 = fwd_wb_en && (fwd_wb_rd == rs2_addr_q) && (rs2_addr_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            sel_q       <= SEL_W'(ALU_ADD);
            use_pc_q    <= 1'b0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q     <= in_valid;
            pc_q        <= in_pc;
            rs1_data_q  <= in_rs1_fwd;
            rs2_data_q  <= in_rs2_fwd;
            imm_q       <= in_imm;
            rs1_addr_q  <= in_rs1_addr;
            rs2_addr_q  <= in_rs2_addr;
            rd_addr_q   <= in_rd_addr;
            sel_q       <= in_alu_sel;
            use_pc_q    <= in_use_pc;
            use_imm_q   <= in_use_imm;
            reg_write_q <= in_reg_write;
        end else begin
            // Stalled: WB will retire before we leave, so absorb its result now.
            if (wb_hit_rs1) rs1_data_q <= fwd_wb_data;
            if (wb_hit_rs2) rs2_data_q <= fwd_wb_data;
        end
    end

    assign out_valid     = valid_q;
    assign alu_a         = use_pc_q  ? pc_q  : rs1_fwd;
    assign alu_b         = use_imm_q ? imm_q : rs2_fwd;
    assign alu_sel       = sel_q;
    assign out_rs2_data  = rs2_fwd;
    assign out_rd_addr   = rd_addr_q;
    assign out_reg_write = reg_write_q && valid_q;

endmodule
